// File: rtl/toy_mem_req_master_if.sv
// Request/response and memory-port bundle for toy_mem_req_master.
//   master : the request master itself (accepts req_*, returns rsp_*,
//            drives mem_*, receives mem_rd_data)
//   slave  : the environment side (core load/store stage plus data memory)
// Signals: req_vld/req_rdy/req_addr/req_wr/req_size/req_unsigned/req_wdata,
//          rsp_vld/rsp_rdy/rsp_rdata/rsp_err,
//          mem_en/mem_addr/mem_wr_en/mem_wr_data/mem_wr_byte_en/mem_rd_data.
interface toy_mem_req_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    req_vld;
    logic                    req_rdy;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_wr;
    logic [1:0]              req_size;
    logic                    req_unsigned;
    logic [DATA_WIDTH-1:0]   req_wdata;

    logic                    rsp_vld;
    logic                    rsp_rdy;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;

    logic                    mem_en;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_wr_en;
    logic [DATA_WIDTH-1:0]   mem_wr_data;
    logic [DATA_WIDTH/8-1:0] mem_wr_byte_en;
    logic [DATA_WIDTH-1:0]   mem_rd_data;

    modport master (
        input  req_vld, req_addr, req_wr, req_size, req_unsigned, req_wdata,
        output req_rdy,
        output rsp_vld, rsp_rdata, rsp_err,
        input  rsp_rdy,
        output mem_en, mem_addr, mem_wr_en, mem_wr_data, mem_wr_byte_en,
        input  mem_rd_data
    );

    modport slave (
        output req_vld, req_addr, req_wr, req_size, req_unsigned, req_wdata,
        input  req_rdy,
        input  rsp_vld, rsp_rdata, rsp_err,
        output rsp_rdy,
        input  mem_en, mem_addr, mem_wr_en, mem_wr_data, mem_wr_byte_en,
        output mem_rd_data
    );
endinterface

// File: rtl/toy_mem_req_master.sv
// Load/store initiator for a single-cycle-latency data memory.
// Accepts byte/halfword/word requests, drives word address, byte enables and
// lane-replicated write data for one cycle, then returns extended load data
// or a misalignment error on the response channel.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : toy_mem_req_master_if.master (request, response and memory port)
module toy_mem_req_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    toy_mem_req_master_if.master  bus
);
    localparam int unsigned BE_W = DATA_WIDTH / 8;

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("toy_mem_req_master: only DATA_WIDTH=32 is supported");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    state_t                state_q, state_n;
    logic [1:0]            lat_addr_q, lat_addr_n;
    logic [1:0]            lat_size_q, lat_size_n;
    logic                  lat_uns_q,  lat_uns_n;
    logic                  lat_wr_q,   lat_wr_n;

    logic                  req_rdy_q,   req_rdy_n;
    logic                  rsp_vld_q,   rsp_vld_n;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_n;
    logic                  rsp_err_q,   rsp_err_n;
    logic                  mem_en_q,    mem_en_n;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_n;
    logic                  mem_wr_en_q, mem_wr_en_n;
    logic [DATA_WIDTH-1:0] mem_wd_q,    mem_wd_n;
    logic [BE_W-1:0]       mem_be_q,    mem_be_n;

    logic                  req_bad;
    logic [BE_W-1:0]       req_be;
    logic [DATA_WIDTH-1:0] req_wd;
    logic [DATA_WIDTH-1:0] rd_lane;
    logic [DATA_WIDTH-1:0] rd_ext;

    // Request decode: alignment, lane enables and lane replication.
    always_comb begin
        req_bad = 1'b0;
        req_be  = '0;
        req_wd  = '0;
        case (bus.req_size)
            2'd0: begin
                req_be = 4'b0001 << bus.req_addr[1:0];
                req_wd = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                req_bad = bus.req_addr[0];
                req_be  = 4'b0011 << {bus.req_addr[1], 1'b0};
                req_wd  = {2{bus.req_wdata[15:0]}};
            end
            2'd2: begin
                req_bad = (bus.req_addr[1:0] != 2'b00);
                req_be  = 4'b1111;
                req_wd  = bus.req_wdata;
            end
            default: req_bad = 1'b1;
        endcase
    end

    // Read lane extraction from the latched request attributes.
    always_comb begin
        rd_lane = bus.mem_rd_data >> {lat_addr_q, 3'b000};
        case (lat_size_q)
            2'd0:    rd_ext = lat_uns_q ? {{(DATA_WIDTH-8){1'b0}}, rd_lane[7:0]}
                                        : {{(DATA_WIDTH-8){rd_lane[7]}}, rd_lane[7:0]};
            2'd1:    rd_ext = lat_uns_q ? {{(DATA_WIDTH-16){1'b0}}, rd_lane[15:0]}
                                        : {{(DATA_WIDTH-16){rd_lane[15]}}, rd_lane[15:0]};
            default: rd_ext = bus.mem_rd_data;
        endcase
    end

    // Next-state and next-output logic; every output is the registered
    // version of its *_n value, so req_rdy follows the next state.
    always_comb begin
        state_n     = state_q;
        lat_addr_n  = lat_addr_q;
        lat_size_n  = lat_size_q;
        lat_uns_n   = lat_uns_q;
        lat_wr_n    = lat_wr_q;
        rsp_vld_n   = rsp_vld_q;
        rsp_rdata_n = rsp_rdata_q;
        rsp_err_n   = rsp_err_q;
        mem_en_n    = 1'b0;
        mem_wr_en_n = 1'b0;
        mem_be_n    = '0;
        mem_addr_n  = mem_addr_q;
        mem_wd_n    = mem_wd_q;

        case (state_q)
            IDLE: begin
                if (bus.req_vld && req_rdy_q) begin
                    lat_addr_n = bus.req_addr[1:0];
                    lat_size_n = bus.req_size;
                    lat_uns_n  = bus.req_unsigned;
                    lat_wr_n   = bus.req_wr;
                    if (req_bad) begin
                        state_n     = RESP;
                        rsp_vld_n   = 1'b1;
                        rsp_err_n   = 1'b1;
                        rsp_rdata_n = '0;
                    end else begin
                        state_n     = ISSUE;
                        mem_en_n    = 1'b1;
                        mem_wr_en_n = bus.req_wr;
                        mem_addr_n  = bus.req_addr >> 2;
                        mem_be_n    = bus.req_wr ? req_be : '0;
                        mem_wd_n    = req_wd;
                    end
                end
            end
            ISSUE: begin
                if (lat_wr_q) begin
                    state_n     = RESP;
                    rsp_vld_n   = 1'b1;
                    rsp_err_n   = 1'b0;
                    rsp_rdata_n = '0;
                end else begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                state_n     = RESP;
                rsp_vld_n   = 1'b1;
                rsp_err_n   = 1'b0;
                rsp_rdata_n = rd_ext;
            end
            RESP: begin
                if (bus.rsp_rdy) begin
                    state_n   = IDLE;
                    rsp_vld_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        req_rdy_n = (state_n == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_addr_q  <= '0;
            lat_size_q  <= '0;
            lat_uns_q   <= 1'b0;
            lat_wr_q    <= 1'b0;
            req_rdy_q   <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wr_en_q <= 1'b0;
            mem_wd_q    <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_n;
            lat_addr_q  <= lat_addr_n;
            lat_size_q  <= lat_size_n;
            lat_uns_q   <= lat_uns_n;
            lat_wr_q    <= lat_wr_n;
            req_rdy_q   <= req_rdy_n;
            rsp_vld_q   <= rsp_vld_n;
            rsp_rdata_q <= rsp_rdata_n;
            rsp_err_q   <= rsp_err_n;
            mem_en_q    <= mem_en_n;
            mem_addr_q  <= mem_addr_n;
            mem_wr_en_q <= mem_wr_en_n;
            mem_wd_q    <= mem_wd_n;
            mem_be_q    <= mem_be_n;
        end
    end

    assign bus.req_rdy        = req_rdy_q;
    assign bus.rsp_vld        = rsp_vld_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.mem_en         = mem_en_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wr_en      = mem_wr_en_q;
    assign bus.mem_wr_data    = mem_wd_q;
    assign bus.mem_wr_byte_en = mem_be_q;
endmodule

// File: tb/tb_toy_mem_req_master.sv
// Self-checking bench for toy_mem_req_master: directed scenarios followed by
// randomized load/store traffic, compared against a byte-array memory model.
module tb_toy_mem_req_master;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    toy_mem_req_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    toy_mem_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Single-cycle-latency data memory (64 words) attached to the mem port.
    logic [31:0] mem_words [64];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wr_byte_en[b])
                        mem_words[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_wr_data[8*b +: 8];
            end else begin
                bus.mem_rd_data <= mem_words[bus.mem_addr[5:0]];
            end
        end
    end

    // Reference: byte-addressed memory image.
    logic [7:0] ref_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input int stall);
        int          nb;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        int          cyc;
        int          en_cnt;
        logic [31:0] got_addr;
        logic        got_wr;
        logic [3:0]  got_be;
        logic [31:0] got_wd;

        nb      = 1 << size;
        exp_err = (size == 2'd3) || ((addr % nb) != 0);
        exp_be  = '0;
        exp_wd  = '0;
        exp_rd  = '0;
        if (!exp_err) begin
            for (int i = 0; i < nb; i++) exp_be[(addr % 4) + i] = 1'b1;
            for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
            if (!wr) begin
                for (int i = 0; i < nb; i++) exp_rd = exp_rd | (32'(ref_mem[addr[7:0] + i]) << (8*i));
                if (!uns && nb < 4 && exp_rd[8*nb-1]) exp_rd = exp_rd | ('1 << (8*nb));
            end else begin
                for (int i = 0; i < nb; i++) ref_mem[addr[7:0] + i] = wdata[8*i +: 8];
            end
        end

        @(negedge clk);
        bus.req_addr     = addr;
        bus.req_wr       = wr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        bus.req_vld      = 1'b1;
        cyc = 0;
        while (!bus.req_rdy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20) begin
            check("req_rdy_timeout", 32'(bus.req_rdy), 32'd1);
            bus.req_vld = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req_vld = 1'b0;
        // Scramble request fields; they must be ignored outside IDLE.
        bus.req_addr  = $urandom;
        bus.req_wr    = 1'($urandom);
        bus.req_size  = 2'($urandom);
        bus.req_wdata = $urandom;

        cyc = 1;
        en_cnt = 0;
        got_addr = '0; got_wr = 1'b0; got_be = '0; got_wd = '0;
        @(negedge clk);
        while (!bus.rsp_vld && cyc < 20) begin
            if (bus.mem_en) begin
                en_cnt++;
                got_addr = bus.mem_addr;
                got_wr   = bus.mem_wr_en;
                got_be   = bus.mem_wr_byte_en;
                got_wd   = bus.mem_wr_data;
            end
            @(negedge clk);
            cyc++;
        end
        check("rsp_latency", 32'(cyc), exp_err ? 32'd1 : (wr ? 32'd2 : 32'd3));
        check("mem_en_cycles", 32'(en_cnt), exp_err ? 32'd0 : 32'd1);
        if (!exp_err) begin
            check("mem_addr", got_addr, addr >> 2);
            check("mem_wr_en", 32'(got_wr), 32'(wr));
            check("mem_byte_en", 32'(got_be), wr ? 32'(exp_be) : 32'd0);
            if (wr) check("mem_wr_data", got_wd, exp_wd);
        end

        for (int s = 0; s < stall; s++) begin
            check("stall_rsp_vld", 32'(bus.rsp_vld), 32'd1);
            check("stall_rdata", bus.rsp_rdata, exp_rd);
            check("stall_req_rdy", 32'(bus.req_rdy), 32'd0);
            check("stall_mem_en", 32'(bus.mem_en), 32'd0);
            @(negedge clk);
        end
        check("rsp_rdata", bus.rsp_rdata, exp_rd);
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        check("rsp_mem_en", 32'(bus.mem_en), 32'd0);
        bus.rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_rdy = 1'b0;
        @(negedge clk);
        check("post_rsp_req_rdy", 32'(bus.req_rdy), 32'd1);
        check("post_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    endtask

    initial begin
        int cyc;
        bus.req_vld      = 1'b0;
        bus.req_addr     = '0;
        bus.req_wr       = 1'b0;
        bus.req_size     = '0;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = '0;
        bus.rsp_rdy      = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
        check("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wr_data", bus.mem_wr_data, 32'd0);
        check("rst_mem_be", 32'(bus.mem_wr_byte_en), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_rdy", 32'(bus.req_rdy), 32'd1);

        // Initialise every memory word through the DUT.
        for (int w = 0; w < 64; w++) do_req(32'(w * 4), 1'b1, 2'd2, 1'b0, $urandom, 0);

        // Word store / load.
        do_req(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 0);
        do_req(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 0);
        // Byte store and signed/unsigned byte loads.
        do_req(32'h13, 1'b1, 2'd0, 1'b0, 32'h000000A5, 0);
        do_req(32'h13, 1'b0, 2'd0, 1'b0, 32'h0, 0);
        do_req(32'h13, 1'b0, 2'd0, 1'b1, 32'h0, 0);
        // Halfword at 0x22.
        do_req(32'h20, 1'b1, 2'd2, 1'b0, 32'h80011234, 0);
        do_req(32'h22, 1'b0, 2'd1, 1'b0, 32'h0, 0);
        do_req(32'h22, 1'b1, 2'd1, 1'b0, 32'h00005A5A, 0);
        do_req(32'h22, 1'b0, 2'd1, 1'b1, 32'h0, 0);
        // Error requests.
        do_req(32'h1, 1'b0, 2'd1, 1'b0, 32'h0, 0);
        do_req(32'h6, 1'b1, 2'd2, 1'b0, 32'h12345678, 0);
        do_req(32'h8, 1'b0, 2'd3, 1'b0, 32'h0, 0);
        // Backpressure on a load.
        do_req(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 5);

        // Reset while in CAPTURE discards the read.
        @(negedge clk);
        bus.req_addr = 32'h10; bus.req_wr = 1'b0; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_vld = 1'b1;
        cyc = 0;
        while (!bus.req_rdy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rstmid_req_rdy", 32'(bus.req_rdy), 32'd1);
        @(posedge clk);
        #1;
        bus.req_vld = 1'b0;
        @(negedge clk);
        check("rstmid_issue_en", 32'(bus.mem_en), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_rsp_vld", 32'(bus.rsp_vld), 32'd0);
        check("rstmid_mem_en", 32'(bus.mem_en), 32'd0);
        check("rstmid_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rstmid_req_rdy_low", 32'(bus.req_rdy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_req_rdy_back", 32'(bus.req_rdy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("rstmid_no_rsp", 32'(bus.rsp_vld), 32'd0);
            @(negedge clk);
        end
        do_req(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 0);

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            do_req({24'd0, 8'($urandom)}, 1'($urandom), 2'($urandom), 1'($urandom),
                   $urandom, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog: always reaches the summary line.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/toy_mem_req_master.md
Name: toy_mem_req_master

Overview:
- Initiator for the single-cycle-latency data memory port: the en / addr / wr_en / wr_byte_en / wr_data drive and the rd_data return one clock later.
- Accepts byte, halfword and word load/store requests from the core over a valid/ready interface.
- Generates word addresses and byte enables, and replicates write data into the correct byte lanes.
- Returns the extracted, sign- or zero-extended read data, or a misalignment error, over a valid/ready response channel.
- Sits between the toy core's load/store stage and the data memory.

Parameters:
ADDR_WIDTH, 32, byte-address width of req_addr and word-address width of mem_addr.
DATA_WIDTH, 32, data width; only 32 is supported, and any other value is a elaboration-time $error.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
req_vld  input  1  request valid.
req_rdy  output  1  request ready; high only in IDLE.
req_addr  input  ADDR_WIDTH  byte address.
req_wr  input  1  1 = store, 0 = load.
req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
req_wdata  input  DATA_WIDTH  store data, right-justified.
rsp_vld  output  1  response valid.
rsp_rdy  input  1  response ready.
rsp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and for errors.
rsp_err  output  1  misaligned or illegal-size request.
mem_en  output  1  memory enable.
mem_addr  output  ADDR_WIDTH  word address, equal to req_addr >> 2 zero-filled.
mem_wr_en  output  1  memory write enable.
mem_wr_data  output  DATA_WIDTH  lane-replicated write data.
mem_wr_byte_en  output  DATA_WIDTH/8  byte-lane enables.
mem_rd_data  input  DATA_WIDTH  memory read data, valid the cycle after the edge that sampled mem_en=1 with mem_wr_en=0.

Behaviour:
- All outputs are registered.
- Values in reset: req_rdy=0, rsp_vld=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, mem_wr_byte_en=0.
- Values after reset: the block is in IDLE, and req_rdy=1 from the first cycle following reset deassertion.
- States:
  - IDLE: req_rdy=1. A handshake (req_vld & req_rdy) at edge t0 latches addr[1:0], size, unsigned and wr.
    - Legal request: drive mem_* and go to ISSUE.
    - Misaligned or illegal request: go to RESP with rsp_err=1 and rsp_rdata=0; no memory access.
  - ISSUE: exactly one cycle; mem_en=1, and mem_wr_en=req_wr. The memory samples at edge t1.
    - Write: next state RESP with rsp_rdata=0 and rsp_err=0, so rsp_vld rises after t1.
    - Read: next state CAPTURE.
  - CAPTURE: one cycle; mem_en=0. At edge t2, mem_rd_data is extracted into rsp_rdata; next state RESP, so rsp_vld rises after t2.
  - RESP: rsp_vld=1, and rsp_rdata/rsp_err are held stable until rsp_rdy=1. On the handshake edge the block returns to IDLE. There is no request/response overlap.
- Alignment rules:
  - size 1 with addr[0]=1 is misaligned.
  - size 2 with addr[1:0]!=0 is misaligned.
  - size 3 is always illegal.
- Byte enables:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: 4'b0011 << {addr[1],1'b0}.
  - size 2: 4'b1111.
  - mem_wr_byte_en=0 on loads.
- Write data:
  - size 0: wdata[7:0] replicated x4.
  - size 1: wdata[15:0] replicated x2.
  - size 2: wdata as-is.
- Read extraction:
  - The selected lane is mem_rd_data >> (addr[1:0]*8), truncated to 8 or 16 bits per size.
  - Sign-extended from the top bit of the lane when req_unsigned=0, else zero-extended.
  - Word loads pass through unchanged.
- mem_en, mem_wr_en and mem_wr_byte_en are 0 in every state except ISSUE. mem_addr and mem_wr_data may hold stale values outside ISSUE.
- rst asserted in any state: at that edge the state returns to IDLE and all outputs take their values in reset. A pending ISSUE write is suppressed if rst is sampled high on the edge where ISSUE would begin. An in-flight read is discarded.
- req inputs are ignored outside IDLE.

Test Plan:
1. Word store, then word load of the same location:
   - store addr=0x10, wdata=0xDEADBEEF: mem_en=1 for one cycle with mem_addr=0x4, byte_en=4'hF; rsp_vld rises 2 cycles after acceptance with rdata=0, err=0.
   - load addr=0x10: rsp_rdata=0xDEADBEEF, with rsp_vld rising 3 cycles after acceptance.
2. Byte store then byte loads:
   - store addr=0x13, wdata=0x000000A5: byte_en=4'b1000, wr_data=0xA5A5A5A5.
   - load with addr=0x13, unsigned=0: rdata=0xFFFFFFA5.
   - load with addr=0x13, unsigned=1: rdata=0x000000A5.
3. Halfword at addr=0x22, memory word 0x8001_1234:
   - signed load: rdata=0xFFFF8001.
   - store of 0x5A5A: byte_en=4'b1100, wr_data=0x5A5A5A5A.
4. Error requests, none of which may assert mem_en:
   - halfword at 0x1, word at 0x6 and size=3 each give rsp_err=1, rdata=0, rsp_vld one cycle after acceptance.
5. Response backpressure:
   - hold rsp_rdy=0 for 5 cycles during a load: rsp_vld and rsp_rdata stay stable, req_rdy=0, and mem_en stays 0.
   - then rsp_rdy=1: req_rdy=1 on the next cycle.
6. Reset mid-operation:
   - assert rst while in CAPTURE: next cycle rsp_vld=0, mem_en=0, rsp_rdata=0, and no response is delivered.
   - after rst deasserts: req_rdy=1 and a new word load completes normally.
